// File: rtl/fp_add_pkg.sv
// Shared definitions for the floating-point adder pipeline: default widths,
// the guard/round/sticky width and the unpacked operand layout.
package fp_add_pkg;

    localparam int DEF_EXP_W = 5;
    localparam int DEF_MAN_W = 11;
    localparam int GRS_W     = 3;

    // Unpacked operand as produced by the unpack stage; mantissa carries the hidden bit.
    typedef struct packed {
        logic                 sgn;
        logic [DEF_EXP_W-1:0] exp;
        logic [DEF_MAN_W-1:0] man;
    } fp_operand_t;

endpackage

// File: rtl/fp_align_cmp.sv
// Combinational operand ordering for the alignment stage: picks the larger operand and
// computes the exponent difference. Define FPADD_MAG_SWAP_EN to also order equal exponents by mantissa.
module fp_align_cmp
    import fp_add_pkg::*;
#(
    parameter int EXP_W = DEF_EXP_W,
    parameter int MAN_W = DEF_MAN_W
) (
    input  logic             sgn_a,
    input  logic             sgn_b,
    input  logic [EXP_W-1:0] exp_a,
    input  logic [EXP_W-1:0] exp_b,
    input  logic [MAN_W-1:0] man_a,
    input  logic [MAN_W-1:0] man_b,
    output logic             swap,
    output logic             sgn_big,
    output logic             sgn_small,
    output logic [EXP_W-1:0] exp_big,
    output logic [MAN_W-1:0] man_big,
    output logic [MAN_W-1:0] man_small,
    output logic [EXP_W-1:0] diff
);

`ifdef FPADD_MAG_SWAP_EN
    // Larger magnitude first, so a later subtraction never goes negative.
    assign swap = (exp_b > exp_a) || ((exp_b == exp_a) && (man_b > man_a));
`else
    assign swap = exp_b > exp_a;
`endif

    assign sgn_big   = swap ? sgn_b : sgn_a;
    assign sgn_small = swap ? sgn_a : sgn_b;
    assign exp_big   = swap ? exp_b : exp_a;
    assign man_big   = swap ? man_b : man_a;
    assign man_small = swap ? man_a : man_b;
    assign diff      = swap ? (exp_b - exp_a) : (exp_a - exp_b);

endmodule

// File: rtl/fp_align_pipe.sv
// Two-stage FP operand alignment: S1 holds the ordered operands, S2 the shifted small
// mantissa with guard/round/sticky. Honours FPADD_MAG_SWAP_EN through fp_align_cmp.
module fp_align_pipe
    import fp_add_pkg::*;
#(
    parameter int EXP_W = DEF_EXP_W,
    parameter int MAN_W = DEF_MAN_W
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic                   in_valid,
    output logic                   in_ready,
    input  logic                   in_sgn_a,
    input  logic                   in_sgn_b,
    input  logic [EXP_W-1:0]       in_exp_a,
    input  logic [EXP_W-1:0]       in_exp_b,
    input  logic [MAN_W-1:0]       in_man_a,
    input  logic [MAN_W-1:0]       in_man_b,
    output logic                   out_valid,
    input  logic                   out_ready,
    output logic                   out_sgn_big,
    output logic                   out_sgn_small,
    output logic [EXP_W-1:0]       out_exp,
    output logic [MAN_W-1:0]       out_man_big,
    output logic [MAN_W+GRS_W-1:0] out_man_small,
    output logic [EXP_W-1:0]       out_shift,
    output logic                   out_swapped,
    output logic                   out_eff_sub
);

    localparam int SH_W = MAN_W + GRS_W;

    logic             c_swap, c_sgn_big, c_sgn_small;
    logic [EXP_W-1:0] c_exp_big, c_diff;
    logic [MAN_W-1:0] c_man_big, c_man_small;

    logic             v1, s1_swapped, s1_sgn_big, s1_sgn_small;
    logic [EXP_W-1:0] s1_exp, s1_diff;
    logic [MAN_W-1:0] s1_man_big, s1_man_small;
    logic             v2;
    logic             s1_load, s2_load;

    logic [SH_W-1:0]  ext, shifted, lost_mask, aligned;

    fp_align_cmp #(.EXP_W(EXP_W), .MAN_W(MAN_W)) u_cmp (
        .sgn_a     (in_sgn_a),
        .sgn_b     (in_sgn_b),
        .exp_a     (in_exp_a),
        .exp_b     (in_exp_b),
        .man_a     (in_man_a),
        .man_b     (in_man_b),
        .swap      (c_swap),
        .sgn_big   (c_sgn_big),
        .sgn_small (c_sgn_small),
        .exp_big   (c_exp_big),
        .man_big   (c_man_big),
        .man_small (c_man_small),
        .diff      (c_diff)
    );

    assign s2_load     = !v2 || out_ready;
    assign s1_load     = !v1 || s2_load;
    assign in_ready    = s1_load;
    assign out_valid   = v2;
    assign out_eff_sub = out_sgn_big ^ out_sgn_small;

    // NOTE: every branch assigns every variable, so no latch is inferred.
    always_comb begin
        ext       = {s1_man_small, {GRS_W{1'b0}}};
        shifted   = ext >> s1_diff;
        lost_mask = ~({SH_W{1'b1}} << s1_diff);
        if (int'(s1_diff) >= SH_W)
            aligned = {{(SH_W-1){1'b0}}, |s1_man_small};
        else
            aligned = {shifted[SH_W-1:1], shifted[0] | (|(ext & lost_mask))};
    end

    // NOTE: state uses non-blocking assignments; data registers are reset too so outputs read 0 after reset.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            v1           <= 1'b0;
            s1_swapped   <= 1'b0;
            s1_sgn_big   <= 1'b0;
            s1_sgn_small <= 1'b0;
            s1_exp       <= '0;
            s1_diff      <= '0;
            s1_man_big   <= '0;
            s1_man_small <= '0;
        end else if (s1_load) begin
            v1 <= in_valid;
            if (in_valid) begin
                s1_swapped   <= c_swap;
                s1_sgn_big   <= c_sgn_big;
                s1_sgn_small <= c_sgn_small;
                s1_exp       <= c_exp_big;
                s1_diff      <= c_diff;
                s1_man_big   <= c_man_big;
                s1_man_small <= c_man_small;
            end
        end
    end

    // Output registers only move when empty or consumed, which keeps held data stable.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            v2            <= 1'b0;
            out_sgn_big   <= 1'b0;
            out_sgn_small <= 1'b0;
            out_exp       <= '0;
            out_man_big   <= '0;
            out_man_small <= '0;
            out_shift     <= '0;
            out_swapped   <= 1'b0;
        end else if (s2_load) begin
            v2 <= v1;
            if (v1) begin
                out_sgn_big   <= s1_sgn_big;
                out_sgn_small <= s1_sgn_small;
                out_exp       <= s1_exp;
                out_man_big   <= s1_man_big;
                out_man_small <= aligned;
                out_shift     <= s1_diff;
                out_swapped   <= s1_swapped;
            end
        end
    end

endmodule

// File: tb/tb_fp_align_pipe.sv
// Directed bench for fp_align_pipe: alignment vectors, backpressure ordering and async reset.
module tb_fp_align_pipe;
    import fp_add_pkg::*;

    localparam int EW = DEF_EXP_W;
    localparam int MW = DEF_MAN_W;

    logic          clk = 1'b0;
    logic          rst = 1'b1;
    logic          in_valid = 1'b0;
    logic          in_ready;
    logic          in_sgn_a = 1'b0, in_sgn_b = 1'b0;
    logic [EW-1:0] in_exp_a = '0, in_exp_b = '0;
    logic [MW-1:0] in_man_a = '0, in_man_b = '0;
    logic          out_valid;
    logic          out_ready = 1'b1;
    logic          out_sgn_big, out_sgn_small, out_swapped, out_eff_sub;
    logic [EW-1:0] out_exp, out_shift;
    logic [MW-1:0] out_man_big;
    logic [MW+2:0] out_man_small;

    int n_assert = 0;
    int n_fail   = 0;

    always #5 clk = ~clk;

    fp_align_pipe dut (
        .clk           (clk),
        .rst           (rst),
        .in_valid      (in_valid),
        .in_ready      (in_ready),
        .in_sgn_a      (in_sgn_a),
        .in_sgn_b      (in_sgn_b),
        .in_exp_a      (in_exp_a),
        .in_exp_b      (in_exp_b),
        .in_man_a      (in_man_a),
        .in_man_b      (in_man_b),
        .out_valid     (out_valid),
        .out_ready     (out_ready),
        .out_sgn_big   (out_sgn_big),
        .out_sgn_small (out_sgn_small),
        .out_exp       (out_exp),
        .out_man_big   (out_man_big),
        .out_man_small (out_man_small),
        .out_shift     (out_shift),
        .out_swapped   (out_swapped),
        .out_eff_sub   (out_eff_sub)
    );

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_assert++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic drive(input fp_operand_t a, input fp_operand_t b);
        in_sgn_a = a.sgn; in_exp_a = a.exp; in_man_a = a.man;
        in_sgn_b = b.sgn; in_exp_b = b.exp; in_man_b = b.man;
    endtask

    // One isolated transaction with out_ready high: not visible after the accept edge,
    // visible with the expected fields one edge later, gone after the consuming edge.
    task automatic run_one(input string tag, input fp_operand_t a, input fp_operand_t b,
                           input logic esb, input logic ess, input logic [EW-1:0] eexp,
                           input logic [MW-1:0] ebig, input logic [MW+2:0] esmall,
                           input logic [EW-1:0] eshift, input logic esw, input logic esub);
        drive(a, b);
        in_valid = 1'b1;
        chk({tag, " in_ready"}, in_ready, 1);
        @(posedge clk); #1;
        in_valid = 1'b0;
        chk({tag, " valid_lat1"}, out_valid, 0);
        @(posedge clk); #1;
        chk({tag, " valid_lat2"}, out_valid, 1);
        chk({tag, " sgn_big"},    out_sgn_big, esb);
        chk({tag, " sgn_small"},  out_sgn_small, ess);
        chk({tag, " exp"},        out_exp, eexp);
        chk({tag, " man_big"},    out_man_big, ebig);
        chk({tag, " man_small"},  out_man_small, esmall);
        chk({tag, " shift"},      out_shift, eshift);
        chk({tag, " swapped"},    out_swapped, esw);
        chk({tag, " eff_sub"},    out_eff_sub, esub);
        @(posedge clk); #1;
        chk({tag, " valid_after"}, out_valid, 0);
    endtask

    // Stream pair i: a = (0, 10+i, 0x400+i), b = (0, 10, 0x400) -> no swap, shift i,
    // small = 0x2000 >> i with no bits lost for i <= 4.
    task automatic set_pair(input int i);
        fp_operand_t a, b;
        a.sgn = 1'b0; a.exp = EW'(10 + i); a.man = MW'(12'h400 + i);
        b.sgn = 1'b0; b.exp = EW'(10);     b.man = MW'(12'h400);
        drive(a, b);
    endtask

    fp_operand_t op_a, op_b;
    int          idx, k;
    logic        acc_in, acc_out;
    logic [MW+2:0] small_exp;
    logic [13:0]   base_small;

    initial begin
        // Reset state
        #1;
        chk("rst out_valid", out_valid, 0);
        chk("rst in_ready", in_ready, 1);
        chk("rst out_exp", out_exp, 0);
        chk("rst out_man_small", out_man_small, 0);
        @(posedge clk); @(negedge clk);
        rst = 1'b0;
        @(posedge clk); #1;

        // Basic swap
        op_a = '{1'b0, 5'd15, 11'h400}; op_b = '{1'b1, 5'd17, 11'h600};
        run_one("swap", op_a, op_b, 1'b1, 1'b0, 5'd17, 11'h600, 14'h0800, 5'd2, 1'b1, 1'b1);

        // Sticky from shifted-out bits
        op_a = '{1'b0, 5'd16, 11'h400}; op_b = '{1'b0, 5'd12, 11'h401};
        run_one("sticky", op_a, op_b, 1'b0, 1'b0, 5'd16, 11'h400, 14'h0201, 5'd4, 1'b0, 1'b0);

        // Shift beyond the extended width
        op_a = '{1'b0, 5'd30, 11'h400}; op_b = '{1'b0, 5'd1, 11'h400};
        run_one("ovf", op_a, op_b, 1'b0, 1'b0, 5'd30, 11'h400, 14'h0001, 5'd29, 1'b0, 1'b0);
        op_b = '{1'b0, 5'd1, 11'h000};
        run_one("ovf_zero", op_a, op_b, 1'b0, 1'b0, 5'd30, 11'h400, 14'h0000, 5'd29, 1'b0, 1'b0);

        // Equal exponents, diff = 0 passes the small mantissa through with GRS = 000
        op_a = '{1'b0, 5'd15, 11'h400}; op_b = '{1'b0, 5'd15, 11'h500};
`ifdef FPADD_MAG_SWAP_EN
        run_one("eq_exp", op_a, op_b, 1'b0, 1'b0, 5'd15, 11'h500, 14'h2000, 5'd0, 1'b1, 1'b0);
`else
        run_one("eq_exp", op_a, op_b, 1'b0, 1'b0, 5'd15, 11'h400, 14'h2800, 5'd0, 1'b0, 1'b0);
`endif

        // Backpressure: fill with out_ready low, check hold, then drain in order
        out_ready = 1'b0;
        set_pair(0); in_valid = 1'b1;
        @(posedge clk); #1;
        set_pair(1);
        @(posedge clk); #1;
        set_pair(2);
        chk("bp full in_ready", in_ready, 0);
        chk("bp full out_valid", out_valid, 1);
        chk("bp full exp", out_exp, 10);
        repeat (2) @(posedge clk);
        #1;
        chk("bp hold in_ready", in_ready, 0);
        chk("bp hold exp", out_exp, 10);
        chk("bp hold man_big", out_man_big, 11'h400);
        chk("bp hold man_small", out_man_small, 14'h2000);

        out_ready = 1'b1;
        idx = 2; k = 0;
        base_small = 14'h2000;
        for (int cyc = 0; cyc < 40 && k < 5; cyc++) begin
            @(negedge clk);
            acc_in  = in_valid & in_ready;
            acc_out = out_valid & out_ready;
            if (acc_out) begin
                small_exp = base_small >> k;
                chk($sformatf("bp out%0d exp", k), out_exp, 32'(10 + k));
                chk($sformatf("bp out%0d man_big", k), out_man_big, 32'(12'h400 + k));
                chk($sformatf("bp out%0d man_small", k), out_man_small, small_exp);
                chk($sformatf("bp out%0d shift", k), out_shift, 32'(k));
                k++;
            end
            @(posedge clk); #1;
            if (acc_in) begin
                idx++;
                if (idx < 5) set_pair(idx);
                else in_valid = 1'b0;
            end
        end
        chk("bp drained count", 32'(k), 5);
        chk("bp accepted count", 32'(idx), 5);
        @(posedge clk); #1;
        chk("bp no extra", out_valid, 0);

        // Asynchronous reset with two transactions in flight
        out_ready = 1'b0;
        set_pair(0); in_valid = 1'b1;
        @(posedge clk); #1;
        set_pair(1);
        @(posedge clk); #1;
        in_valid = 1'b0;
        chk("rst_mid pre out_valid", out_valid, 1);
        #1 rst = 1'b1;
        #1;
        chk("rst_mid out_valid", out_valid, 0);
        chk("rst_mid in_ready", in_ready, 1);
        chk("rst_mid out_exp", out_exp, 0);
        @(negedge clk);
        rst = 1'b0;
        out_ready = 1'b1;
        @(posedge clk); #1;
        chk("post_rst out_valid", out_valid, 0);
        op_a = '{1'b0, 5'd15, 11'h400}; op_b = '{1'b1, 5'd17, 11'h600};
        run_one("post_rst", op_a, op_b, 1'b1, 1'b0, 5'd17, 11'h600, 14'h0800, 5'd2, 1'b1, 1'b1);

        $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
        $finish;
    end

endmodule

// File: doc/fp_align_pipe.md
# fp_align_pipe

Parametrised, pipelined operand-alignment stage for the floating-point adder. Each cycle it accepts two unpacked operands (sign, exponent, mantissa with hidden bit) and orders them so the larger-exponent operand is first. It then right-shifts the smaller mantissa by the exponent difference, producing guard/round/sticky bits. It sits between operand unpacking and the mantissa add/subtract stage, with valid/ready flow control on both sides.

## Interface
- `EXP_W`, 5, exponent width
- `MAN_W`, 11, mantissa width including hidden bit (MSB)

- `clk`  in  1  clock, rising edge
- `rst`  in  1  reset, asynchronous, active-high
- `in_valid`  in  1  input operand pair valid
- `in_ready`  out  1  stage can accept input this cycle
- `in_sgn_a`, `in_sgn_b`  in  1  operand signs
- `in_exp_a`, `in_exp_b`  in  EXP_W  biased exponents
- `in_man_a`, `in_man_b`  in  MAN_W  mantissas
- `out_valid`  out  1  aligned result valid
- `out_ready`  in  1  downstream accepts result
- `out_sgn_big`, `out_sgn_small`  out  1  signs after ordering
- `out_exp`  out  EXP_W  larger exponent (result exponent)
- `out_man_big`  out  MAN_W  larger-exponent mantissa, unshifted
- `out_man_small`  out  MAN_W+3  smaller mantissa, shifted, with low three bits = guard, round, sticky
- `out_shift`  out  EXP_W  exponent difference applied
- `out_swapped`  out  1  operand b was placed first
- `out_eff_sub`  out  1  `out_sgn_big ^ out_sgn_small`

## Operation
- Swap rule: swap when `exp_b > exp_a`. Equal exponents without `FPADD_MAG_SWAP_EN`: no swap.
- Shift amount: `diff = exp_big - exp_small`, unsigned and never negative.
- Extended small mantissa: `{man_small, 3'b000}`, shifted right by `diff`.
- Sticky: bit 0 is the OR of every bit shifted out below bit 0, ORed with the bit 0 already in place.
- `diff >= MAN_W+3`: all bits zero except sticky, which equals `|man_small`.
- `diff = 0`: small mantissa passes through unchanged, GRS = 000.
- Zero or denormal operands get no special handling; mantissas are processed as given.

## Timing
- Two register stages:
  - S1 registers compare/swap results and `diff`.
  - S2 registers the shifter output.
- Latency: 2 cycles from input accept to `out_valid`. Throughput: 1 per cycle.
- Handshake:
  - Input accepted on `in_valid & in_ready`.
  - Output consumed on `out_valid & out_ready`.
  - `out_valid` and `out_valid` output data hold stable until consumed.
- Stage advance:
  - S2 loads when `!v2 | out_ready`.
  - S1 loads when `!v1 | s2_load`.
  - `in_ready = !v1 | s2_load` (combinational; no dependency on `in_valid`).
- Full pipe with `out_ready` low: exactly 2 transactions held, `in_ready = 0`. No loss, duplication or reordering.
- Simultaneous accept and consume while full: all stages advance in the same cycle.
- Reset values:
  - `v1 = v2 = 0`, so `out_valid = 0`.
  - All output data registers 0.
  - `in_ready = 1`.
- Reset asserted mid-operation discards in-flight data immediately (asynchronous).

## Configuration
- `FPADD_MAG_SWAP_EN` defined: on equal exponents, swap when `man_b > man_a`. Equal mantissas: no swap. The larger magnitude is always first, so subtraction never yields a negative mantissa.
- Undefined: equal exponents never swap. The mantissa comparator is absent.

## Structure
- Package `fp_add_pkg`:
  - default `EXP_W` and `MAN_W`
  - `GRS_W = 3`
  - packed operand typedef `{sgn, exp, man}`, shared with the unpack and add stages
- Sub-module `fp_align_cmp` (combinational): exponent and optional mantissa compare, swap mux, `diff`. Instantiated before S1.
- Shifter plus sticky reduction live inline in `fp_align_pipe` between S1 and S2.

## Test plan
- Basic swap: a = (0, 15, 0x400), b = (1, 17, 0x600).
  - Out: exp 17, man_big 0x600, man_small 0x0800, shift 2, swapped 1, eff_sub 1, after 2 cycles.
- Sticky: a = (0, 16, 0x400), b = (0, 12, 0x401).
  - Out: man_small 0x201, shift 4, swapped 0.
- Overflow shift: a = (0, 30, 0x400), b = (0, 1, 0x400).
  - Out: man_small 0x0001.
  - With b man = 0: man_small 0x0000.
- Equal exponents: a = (0, 15, 0x400), b = (0, 15, 0x500).
  - Without macro: swapped 0.
  - With `FPADD_MAG_SWAP_EN`: swapped 1, man_big 0x500.
- Backpressure: stream 5 pairs back-to-back with `out_ready` low for cycles 2–5.
  - `in_ready` drops after 2 are held.
  - All 5 emerge in order, each exactly once.
  - Outputs stay stable while stalled.
- Reset: assert `rst` with 2 transactions in flight.
  - `out_valid` goes to 0 asynchronously.
  - After release, `in_ready = 1` and the next input emerges alone with 2-cycle latency.
